// File: rtl/branch_decode_stage.sv
// branch_decode_stage: resolves or1420 control flow right after fetch and
// registers every instruction toward execute, handling the delay slot.
// Optional build macro BRANCH_DECODE_COUNTERS_EN adds branch/taken counters.
module branch_decode_stage #(
    parameter logic [31:0] NOP_INSTRUCTION = 32'h1500FFFF
) (
    input  logic        cpuClock,
    input  logic        cpuReset,
    input  logic        stallIn,
    input  logic [31:0] instructionIn,
    input  logic        validInstructionIn,
    input  logic [29:0] programCounterIn,
    input  logic [29:0] linkAddressIn,
    input  logic        flagIn,
    input  logic        flagPendingIn,
    input  logic [31:0] rbValueIn,
    input  logic        execWeIn,
    input  logic [4:0]  execDestIn,
    output logic        doJump,
    output logic [29:0] jumpTarget,
    output logic        insertNop,
    output logic [31:0] instructionOut,
    output logic [29:0] programCounterOut,
    output logic        linkWriteOut,
    output logic [29:0] linkAddressOut,
    output logic        validOut,
    output logic        illegalSlotOut
`ifdef BRANCH_DECODE_COUNTERS_EN
    ,
    output logic [31:0] branchCountOut,
    output logic [31:0] takenCountOut
`endif
);

    typedef enum logic [1:0] {NORMAL, HAZARD, DELAY_SLOT} state_t;

    state_t      state_q, state_d;
    logic [31:0] instruction_q, instruction_d;
    logic [29:0] program_counter_q, program_counter_d;
    logic        link_write_q, link_write_d;
    logic [29:0] link_address_q, link_address_d;
    logic        valid_q, valid_d;
    logic        illegal_slot_q, illegal_slot_d;

    logic [5:0]  opcode;
    logic        is_j, is_jal, is_bnf, is_bf, is_jr, is_jalr;
    logic        is_cf, is_reg, taken, haz_f, haz_r, hazard;
    logic [29:0] rel_target, target;
    logic        unused_rb_low;

    assign unused_rb_low = ^rbValueIn[1:0];

    // Opcode decode, target computation and hazard detection
    always_comb begin
        opcode     = instructionIn[31:26];
        is_j       = (opcode == 6'h00);
        is_jal     = (opcode == 6'h01);
        is_bnf     = (opcode == 6'h03);
        is_bf      = (opcode == 6'h04);
        is_jr      = (opcode == 6'h11);
        is_jalr    = (opcode == 6'h12);
        is_reg     = is_jr | is_jalr;
        is_cf      = is_j | is_jal | is_bnf | is_bf | is_reg;
        // Relative offset is in words; the add wraps modulo 2^30.
        rel_target = programCounterIn + {{4{instructionIn[25]}}, instructionIn[25:0]};
        target     = is_reg ? rbValueIn[31:2] : rel_target;
        taken      = is_j | is_jal | is_reg | (is_bf & flagIn) | (is_bnf & ~flagIn);
        haz_f      = (is_bf | is_bnf) & flagPendingIn;
        haz_r      = is_reg & execWeIn & (execDestIn == instructionIn[15:11])
                     & (execDestIn != 5'd0);
        hazard     = haz_f | haz_r;
    end

    // Next-state, redirect outputs and next values of the execute-side registers
    always_comb begin
        state_d           = state_q;
        instruction_d     = instruction_q;
        program_counter_d = program_counter_q;
        link_write_d      = link_write_q;
        link_address_d    = link_address_q;
        valid_d           = valid_q;
        illegal_slot_d    = 1'b0;
        doJump            = 1'b0;
        insertNop         = 1'b0;
        jumpTarget        = target;
        if (!stallIn) begin
            program_counter_d = programCounterIn;
            link_address_d    = linkAddressIn;
            valid_d           = 1'b1;
            link_write_d      = 1'b0;
            if (!validInstructionIn) begin
                // Fetch bus error: forward the word marked invalid, no decode.
                instruction_d = instructionIn;
                valid_d       = 1'b0;
            end else if (state_q == DELAY_SLOT) begin
                // Control flow in a delay slot is squashed and flagged.
                instruction_d  = is_cf ? NOP_INSTRUCTION : instructionIn;
                illegal_slot_d = is_cf;
                state_d        = NORMAL;
            end else if (hazard) begin
                insertNop     = 1'b1;
                instruction_d = NOP_INSTRUCTION;
                state_d       = HAZARD;
            end else begin
                instruction_d = instructionIn;
                link_write_d  = is_jal | is_jalr;
                doJump        = taken;
                state_d       = taken ? DELAY_SLOT : NORMAL;
            end
        end
    end

    // Pipeline register toward execute plus the control state
    always_ff @(posedge cpuClock or posedge cpuReset) begin
        if (cpuReset) begin
            state_q           <= NORMAL;
            instruction_q     <= NOP_INSTRUCTION;
            program_counter_q <= 30'd0;
            link_write_q      <= 1'b0;
            link_address_q    <= 30'd0;
            valid_q           <= 1'b1;
            illegal_slot_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            instruction_q     <= instruction_d;
            program_counter_q <= program_counter_d;
            link_write_q      <= link_write_d;
            link_address_q    <= link_address_d;
            valid_q           <= valid_d;
            illegal_slot_q    <= illegal_slot_d;
        end
    end

    assign instructionOut    = instruction_q;
    assign programCounterOut = program_counter_q;
    assign linkWriteOut      = link_write_q;
    assign linkAddressOut    = link_address_q;
    assign validOut          = valid_q;
    assign illegalSlotOut    = illegal_slot_q;

`ifdef BRANCH_DECODE_COUNTERS_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] taken_count_q, taken_count_d;

    // Count consumed control-flow instructions and redirects issued
    always_comb begin
        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;
        if (!stallIn && validInstructionIn && state_q != DELAY_SLOT && is_cf && !hazard)
            branch_count_d = branch_count_q + 32'd1;
        if (doJump)
            taken_count_d = taken_count_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge cpuClock or posedge cpuReset) begin
        if (cpuReset) begin
            branch_count_q <= 32'd0;
            taken_count_q  <= 32'd0;
        end else begin
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign branchCountOut = branch_count_q;
    assign takenCountOut  = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_decode_stage.sv
// Directed, table-driven bench for branch_decode_stage.
module tb_branch_decode_stage;

    localparam logic [31:0] NOP  = 32'h1500FFFF;
    localparam logic [31:0] ADDI = 32'h9C210004;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] instr;
    logic        vin;
    logic [29:0] pc, link;
    logic        flag, fpend;
    logic [31:0] rb;
    logic        ewe;
    logic [4:0]  edest;
    logic        do_jump, ins_nop, lw_out, v_out, ill_out;
    logic [29:0] tgt, pc_out, link_out;
    logic [31:0] i_out;
`ifdef BRANCH_DECODE_COUNTERS_EN
    logic [31:0] bcnt, tcnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_decode_stage dut (
        .cpuClock(clk), .cpuReset(rst), .stallIn(stall),
        .instructionIn(instr), .validInstructionIn(vin),
        .programCounterIn(pc), .linkAddressIn(link),
        .flagIn(flag), .flagPendingIn(fpend), .rbValueIn(rb),
        .execWeIn(ewe), .execDestIn(edest),
        .doJump(do_jump), .jumpTarget(tgt), .insertNop(ins_nop),
        .instructionOut(i_out), .programCounterOut(pc_out),
        .linkWriteOut(lw_out), .linkAddressOut(link_out),
        .validOut(v_out), .illegalSlotOut(ill_out)
`ifdef BRANCH_DECODE_COUNTERS_EN
        , .branchCountOut(bcnt), .takenCountOut(tcnt)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic [29:0] pc;
        logic [29:0] link;
        logic        flag;
        logic        fpend;
        logic [31:0] rb;
        logic        ewe;
        logic [4:0]  edest;
        logic        e_jump;
        logic [29:0] e_tgt;
        logic        e_nop;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_lw;
        logic        e_ill;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instr = v.instr; vin = v.valid; pc = v.pc; link = v.link;
        flag = v.flag; fpend = v.fpend; rb = v.rb; ewe = v.ewe; edest = v.edest;
    endtask

    initial begin
        // instr valid pc link flag fpend rb ewe edest | jump tgt nop instrOut valid lw ill
        tbl[0]  = '{32'h00000004, 1'b1, 30'h100, 30'h102, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 30'h104, 1'b0, 32'h00000004, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{ADDI,         1'b1, 30'h101, 30'h103, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0,   1'b0, ADDI,         1'b1, 1'b0, 1'b0};
        tbl[2]  = '{32'h13FFFFFE, 1'b1, 30'h200, 30'h202, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 30'h1FE, 1'b0, 32'h13FFFFFE, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{ADDI,         1'b1, 30'h201, 30'h203, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0,   1'b0, ADDI,         1'b1, 1'b0, 1'b0};
        tbl[4]  = '{32'h13FFFFFE, 1'b1, 30'h300, 30'h302, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0,   1'b0, 32'h13FFFFFE, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{32'h0C000008, 1'b1, 30'h310, 30'h312, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 30'h318, 1'b0, 32'h0C000008, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{32'h04000010, 1'b1, 30'h311, 30'h313, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0,   1'b0, NOP,          1'b1, 1'b0, 1'b1};
        tbl[7]  = '{ADDI,         1'b1, 30'h312, 30'h314, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0,   1'b0, ADDI,         1'b1, 1'b0, 1'b0};
        tbl[8]  = '{32'h44001800, 1'b1, 30'h400, 30'h402, 1'b0, 1'b0, 32'h2008, 1'b1, 5'd3, 1'b0, 30'h0, 1'b1, NOP,          1'b1, 1'b0, 1'b0};
        tbl[9]  = '{32'h44001800, 1'b1, 30'h400, 30'h402, 1'b0, 1'b0, 32'h2008, 1'b0, 5'd3, 1'b1, 30'h802, 1'b0, 32'h44001800, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{ADDI,         1'b1, 30'h401, 30'h403, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0,   1'b0, ADDI,         1'b1, 1'b0, 1'b0};
        tbl[11] = '{32'h44000000, 1'b1, 30'h410, 30'h412, 1'b0, 1'b0, 32'h13, 1'b1, 5'd0, 1'b1, 30'h4,   1'b0, 32'h44000000, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{ADDI,         1'b1, 30'h411, 30'h413, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0,   1'b0, ADDI,         1'b1, 1'b0, 1'b0};
        tbl[13] = '{32'h48002800, 1'b1, 30'h500, 30'h502, 1'b0, 1'b0, 32'h1000, 1'b0, 5'd0, 1'b1, 30'h400, 1'b0, 32'h48002800, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{ADDI,         1'b1, 30'h501, 30'h503, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0,   1'b0, ADDI,         1'b1, 1'b0, 1'b0};
        tbl[15] = '{32'h13FFFFFE, 1'b1, 30'h600, 30'h602, 1'b1, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0,   1'b1, NOP,          1'b1, 1'b0, 1'b0};
        tbl[16] = '{32'h13FFFFFE, 1'b1, 30'h600, 30'h602, 1'b1, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0,   1'b1, NOP,          1'b1, 1'b0, 1'b0};
        tbl[17] = '{32'h13FFFFFE, 1'b1, 30'h600, 30'h602, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0,   1'b0, 32'h13FFFFFE, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{32'h00000004, 1'b0, 30'h610, 30'h612, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0,   1'b0, 32'h00000004, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{32'h03FFFFFF, 1'b1, 30'h0,   30'h2,   1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 30'h3FFFFFFF, 1'b0, 32'h03FFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{ADDI,         1'b1, 30'h1,   30'h3,   1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0,   1'b0, ADDI,         1'b1, 1'b0, 1'b0};
        tbl[21] = '{32'h00000010, 1'b1, 30'h3FFFFFF8, 30'h3FFFFFFA, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 30'h8, 1'b0, 32'h00000010, 1'b1, 1'b0, 1'b0};
        tbl[22] = '{ADDI,         1'b1, 30'h3FFFFFF9, 30'h3FFFFFFB, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 30'h0, 1'b0, ADDI,     1'b1, 1'b0, 1'b0};

        rst = 1'b1; stall = 1'b0;
        instr = ADDI; vin = 1'b1; pc = '0; link = '0; flag = 1'b0; fpend = 1'b0;
        rb = '0; ewe = 1'b0; edest = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_instr", i_out, NOP);
        chk("reset_valid", 32'(v_out), 32'd1);
        chk("reset_lw", 32'(lw_out), 32'd0);
        chk("reset_ill", 32'(ill_out), 32'd0);
        chk("reset_pc", 32'(pc_out), 32'd0);
        chk("reset_link", 32'(link_out), 32'd0);
`ifdef BRANCH_DECODE_COUNTERS_EN
        chk("reset_bcnt", bcnt, 32'd0);
        chk("reset_tcnt", tcnt, 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_dojump", i), 32'(do_jump), 32'(tbl[i].e_jump));
            chk($sformatf("v%0d_insnop", i), 32'(ins_nop), 32'(tbl[i].e_nop));
            if (tbl[i].e_jump)
                chk($sformatf("v%0d_target", i), 32'(tgt), 32'(tbl[i].e_tgt));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_instr", i), i_out, tbl[i].e_instr);
            chk($sformatf("v%0d_valid", i), 32'(v_out), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_lw", i), 32'(lw_out), 32'(tbl[i].e_lw));
            chk($sformatf("v%0d_ill", i), 32'(ill_out), 32'(tbl[i].e_ill));
            if (tbl[i].e_instr != NOP) begin
                chk($sformatf("v%0d_pc", i), 32'(pc_out), 32'(tbl[i].pc));
                chk($sformatf("v%0d_link", i), 32'(link_out), 32'(tbl[i].link));
            end
            $display("vec %0d instr=%h jump=%0b tgt=%h nop=%0b out=%h valid=%0b ill=%0b",
                     i, tbl[i].instr, do_jump, tgt, ins_nop, i_out, v_out, ill_out);
            @(negedge clk);
        end
`ifdef BRANCH_DECODE_COUNTERS_EN
        chk("table_bcnt", bcnt, 32'd10);
        chk("table_tcnt", tcnt, 32'd8);
`endif

        // Stall for three cycles with a taken l.j presented
        instr = 32'h00000004; vin = 1'b1; pc = 30'h700; link = 30'h702;
        flag = 1'b0; fpend = 1'b0; rb = '0; ewe = 1'b0; edest = '0;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_dojump", c), 32'(do_jump), 32'd0);
            chk($sformatf("stall%0d_insnop", c), 32'(ins_nop), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_instr", c), i_out, ADDI);
            chk($sformatf("stall%0d_pc", c), 32'(pc_out), 32'h3FFFFFF9);
            chk($sformatf("stall%0d_ill", c), 32'(ill_out), 32'd0);
            $display("stall %0d jump=%0b out=%h pc=%h", c, do_jump, i_out, pc_out);
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        chk("release_dojump", 32'(do_jump), 32'd1);
        chk("release_target", 32'(tgt), 32'h704);
        @(posedge clk);
        #1;
        chk("release_instr", i_out, 32'h00000004);
        $display("release jump=%0b tgt=%h out=%h", do_jump, tgt, i_out);
        @(negedge clk);
        instr = ADDI; pc = 30'h701; link = 30'h703;
        #1;
        chk("release_slot_dojump", 32'(do_jump), 32'd0);
        @(posedge clk);
        #1;
        chk("release_slot_instr", i_out, ADDI);
        $display("release slot jump=%0b out=%h", do_jump, i_out);
        @(negedge clk);
`ifdef BRANCH_DECODE_COUNTERS_EN
        chk("stall_bcnt", bcnt, 32'd11);
        chk("stall_tcnt", tcnt, 32'd9);
`endif

        // Reset while a delay slot is pending, then a jump must be honoured
        instr = 32'h00000004; pc = 30'h800; link = 30'h802;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_instr", i_out, NOP);
        chk("midreset_pc", 32'(pc_out), 32'd0);
        chk("midreset_valid", 32'(v_out), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        instr = 32'h00000004; pc = 30'h900; link = 30'h902;
        #1;
        chk("postreset_dojump", 32'(do_jump), 32'd1);
        chk("postreset_target", 32'(tgt), 32'h904);
        @(posedge clk);
        #1;
        chk("postreset_instr", i_out, 32'h00000004);
        chk("postreset_ill", 32'(ill_out), 32'd0);
        $display("post-reset jump out=%h ill=%0b", i_out, ill_out);
`ifdef BRANCH_DECODE_COUNTERS_EN
        chk("postreset_bcnt", bcnt, 32'd1);
        chk("postreset_tcnt", tcnt, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_decode_stage.md
Name: branch_decode_stage

Overview:
- Sits directly downstream of the or1420 instruction-fetch stage and directly upstream of execute.
- Consumes the fetched instruction, its valid flag, its program counter and its link address.
- Resolves control flow (l.j, l.jal, l.bf, l.bnf, l.jr, l.jalr) and drives doJump, jumpTarget and insertNop back to fetch.
- Handles the architectural delay slot and registers every instruction, with its PC, toward execute.

Parameters:
- NOP_INSTRUCTION, 32'h1500FFFF, bubble word emitted toward execute on reset, hazard or squash.

Ports:
- cpuClock  in  1  single clock, rising edge.
- cpuReset  in  1  reset, asynchronous, active-high.
- stallIn  in  1  global pipeline stall (fetch stallOut | dCacheStall); holds all registers.
- instructionIn  in  32  instruction from fetch.
- validInstructionIn  in  1  fetch valid; 0 = bus error on fetch.
- programCounterIn  in  30  word PC [31:2] of instructionIn.
- linkAddressIn  in  30  PC+8 link value [31:2] from fetch.
- flagIn  in  1  SR[F] as currently committed by execute.
- flagPendingIn  in  1  instruction in execute will write SR[F] this cycle.
- rbValueIn  in  32  register-file read of instructionIn[15:11].
- execWeIn  in  1  execute stage writes a GPR.
- execDestIn  in  5  destination GPR of execute.
- doJump  out  1  redirect fetch (combinational).
- jumpTarget  out  30  redirect target [31:2] (combinational).
- insertNop  out  1  fetch must re-present the same PC (combinational).
- instructionOut  out  32  registered instruction to execute.
- programCounterOut  out  30  registered PC.
- linkWriteOut  out  1  registered; 1 for l.jal/l.jalr (write r9 with linkAddressOut).
- linkAddressOut  out  30  registered link address.
- validOut  out  1  registered valid.
- illegalSlotOut  out  1  one-cycle pulse: control-flow instruction found in a delay slot.

Behaviour:
- Async reset:
  - instructionOut = NOP_INSTRUCTION; validOut = 1; linkWriteOut = 0; illegalSlotOut = 0.
  - programCounterOut = 0; linkAddressOut = 0; state = NORMAL.
- Decode uses opcode = instructionIn[31:26]:
  - 0x00 l.j, 0x01 l.jal, 0x03 l.bnf, 0x04 l.bf, 0x11 l.jr, 0x12 l.jalr.
  - All other opcodes pass through untouched.
- Relative target = programCounterIn + sign-extend(instructionIn[25:0]) to 30 bits, modulo 2^30 (wraps silently).
- Register target = rbValueIn[31:2]; rbValueIn[1:0] is ignored.
- Taken condition:
  - l.j, l.jal, l.jr, l.jalr: always taken.
  - l.bf: taken when flagIn = 1.
  - l.bnf: taken when flagIn = 0.
- Hazards:
  - hazF = (l.bf or l.bnf) & flagPendingIn.
  - hazR = (l.jr or l.jalr) & execWeIn & (execDestIn == instructionIn[15:11]) & (execDestIn != 0).
- State machine, 3 states, advances only when stallIn = 0:
  - NORMAL:
    - If hazF or hazR: insertNop = 1, doJump = 0, bubble registered; go to HAZARD.
    - Else if taken: doJump = 1, jumpTarget = target; instruction registered; go to DELAY_SLOT.
    - Else: instruction registered; stay in NORMAL.
  - HAZARD: same evaluation as NORMAL on the re-presented instruction. A hazard may persist indefinitely; insertNop stays high while it does.
  - DELAY_SLOT:
    - doJump = 0 and insertNop = 0.
    - The next instruction is registered and executed normally.
    - If it is a control-flow opcode: register it as NOP_INSTRUCTION, pulse illegalSlotOut, take no jump.
    - Go to NORMAL after the slot instruction is consumed.
- validInstructionIn = 0 (fetch bus error):
  - No decode, no jump, no hazard.
  - instructionIn is registered with validOut = 0; state unchanged.
- stallIn = 1:
  - doJump = 0 and insertNop = 0.
  - All registers and state hold; illegalSlotOut = 0.
- linkWriteOut = 1 only for a registered l.jal or l.jalr.
- Latency: one cycle from instructionIn to instructionOut; zero cycles from instructionIn to doJump.
- Reset mid-sequence (for example in DELAY_SLOT) returns the block to NORMAL. The pending slot is discarded.

Optional Feature:
- Macro: BRANCH_DECODE_COUNTERS_EN.
- When defined:
  - Add outputs branchCountOut[31:0] and takenCountOut[31:0].
  - Both reset to 0 and wrap at 2^32.
  - branchCountOut increments on each consumed control-flow instruction (stallIn = 0, valid, no hazard, not in a slot).
  - takenCountOut increments on each doJump.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then l.j +4 at PC 0x100: doJump = 1 with jumpTarget 0x104 in the same cycle; next instruction registered as the slot; state returns to NORMAL.
- l.bf at PC 0x200 with N = -2 and flagIn = 1: jumpTarget 0x1FE. With flagIn = 0: doJump = 0 and the instruction passes through.
- l.jr r3 with execWeIn = 1 and execDestIn = 3: insertNop = 1 for one cycle and a bubble is registered. The next cycle with execWeIn = 0 gives doJump = 1 and jumpTarget = rbValueIn[31:2].
- l.jal in a delay slot: instructionOut = 0x1500FFFF, illegalSlotOut pulses for 1 cycle, doJump = 0.
- stallIn = 1 held for 3 cycles with a taken l.j presented: doJump stays 0 and outputs hold. On release, doJump = 1 for exactly one cycle.
- validInstructionIn = 0 with an l.j word: validOut = 0 and no jump. With the counters enabled, neither counter changes.
